rggen_axi4lite_initiator: RTL and testbench

RGGEN_AXI4LITE_INITIATOR -- requirements
Module: rggen_axi4lite_initiator

---
 rtl/rggen_axi4lite_initiator_if.sv | 41 ++++
 rtl/rggen_axi4lite_initiator.sv | 167 ++++++++++++++++
 tb/tb_rggen_axi4lite_initiator.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_axi4lite_initiator_if.sv
// AXI4-Lite channel bundle between the rggen initiator (master) and a register slave.
interface rggen_axi4lite_initiator_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                     awvalid;
    logic                     awready;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [BUS_WIDTH-1:0]     rdata;
    logic [1:0]               rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input rvalid, rdata, rresp, output rready
    );

    modport slave (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );
endinterface

// File: rtl/rggen_axi4lite_initiator.sv
// Host request/response to AXI4-Lite master bridge with a single transaction in flight.
// Define RGGEN_AXI4LITE_INITIATOR_RESPONSE_REGISTER_EN to register the host response path.
module rggen_axi4lite_initiator #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_request_valid,
    output logic                     o_request_ready,
    input  logic                     i_request_write,
    input  logic [ADDRESS_WIDTH-1:0] i_request_address,
    input  logic [BUS_WIDTH-1:0]     i_request_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_request_strobe,
    output logic                     o_response_valid,
    input  logic                     i_response_ready,
    output logic [BUS_WIDTH-1:0]     o_response_read_data,
    output logic [1:0]               o_response_status,
    rggen_axi4lite_initiator_if.master axi
);
    typedef enum logic [2:0] {
        IDLE,
        WRITE_REQUEST,
        READ_REQUEST,
        WAIT_RESPONSE
`ifdef RGGEN_AXI4LITE_INITIATOR_RESPONSE_REGISTER_EN
        , RESPONSE_OUT
`endif
    } state_e;

    state_e                   state;
    logic                     write_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [BUS_WIDTH-1:0]     write_data_q;
    logic [BUS_WIDTH/8-1:0]   strobe_q;
    logic                     awvalid_q;
    logic                     wvalid_q;
    logic                     arvalid_q;
    logic                     aw_done;
    logic                     w_done;
    logic                     aw_hs;
    logic                     w_hs;
    logic                     ar_hs;
    logic                     wait_write;
    logic                     wait_read;

    assign aw_hs      = awvalid_q && axi.awready;
    assign w_hs       = wvalid_q && axi.wready;
    assign ar_hs      = arvalid_q && axi.arready;
    assign wait_write = (state == WAIT_RESPONSE) && write_q;
    assign wait_read  = (state == WAIT_RESPONSE) && !write_q;

    assign o_request_ready = i_rst_n && (state == IDLE);

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = address_q;
    assign axi.awprot  = 3'b000;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = write_data_q;
    assign axi.wstrb   = strobe_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = address_q;
    assign axi.arprot  = 3'b000;

`ifdef RGGEN_AXI4LITE_INITIATOR_RESPONSE_REGISTER_EN
    logic                 response_valid_q;
    logic [BUS_WIDTH-1:0] response_data_q;
    logic [1:0]           response_status_q;

    // Slave side always ready while waiting; the host sees a registered copy.
    assign axi.bready           = wait_write;
    assign axi.rready           = wait_read;
    assign o_response_valid     = i_rst_n && response_valid_q;
    assign o_response_read_data = response_data_q;
    assign o_response_status    = response_status_q;
`else
    // Host handshake and AXI B/R handshake coincide in this build.
    assign axi.bready           = wait_write && i_response_ready;
    assign axi.rready           = wait_read && i_response_ready;
    assign o_response_valid     = i_rst_n && ((wait_write && axi.bvalid) || (wait_read && axi.rvalid));
    assign o_response_read_data = wait_read ? axi.rdata : '0;
    assign o_response_status    = wait_write ? axi.bresp : (wait_read ? axi.rresp : 2'b00);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            write_q      <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
`ifdef RGGEN_AXI4LITE_INITIATOR_RESPONSE_REGISTER_EN
            response_valid_q  <= 1'b0;
            response_data_q   <= '0;
            response_status_q <= 2'b00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_request_valid) begin
                        write_q      <= i_request_write;
                        address_q    <= i_request_address;
                        write_data_q <= i_request_write_data;
                        strobe_q     <= i_request_strobe;
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        if (i_request_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WRITE_REQUEST;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= READ_REQUEST;
                        end
                    end
                end
                WRITE_REQUEST: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state <= WAIT_RESPONSE;
                    end
                end
                READ_REQUEST: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        state     <= WAIT_RESPONSE;
                    end
                end
                WAIT_RESPONSE: begin
`ifdef RGGEN_AXI4LITE_INITIATOR_RESPONSE_REGISTER_EN
                    if (write_q ? axi.bvalid : axi.rvalid) begin
                        response_valid_q  <= 1'b1;
                        response_data_q   <= write_q ? '0 : axi.rdata;
                        response_status_q <= write_q ? axi.bresp : axi.rresp;
                        state             <= RESPONSE_OUT;
                    end
`else
                    if (o_response_valid && i_response_ready) begin
                        state <= IDLE;
                    end
`endif
                end
`ifdef RGGEN_AXI4LITE_INITIATOR_RESPONSE_REGISTER_EN
                RESPONSE_OUT: begin
                    if (i_response_ready) begin
                        response_valid_q <= 1'b0;
                        state            <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rggen_axi4lite_initiator.sv
// Self-checking bench for rggen_axi4lite_initiator: directed scenarios plus randomized traffic
// against a word-memory reference model; expected latency follows the response-register macro.
module tb_rggen_axi4lite_initiator;
`ifdef RGGEN_AXI4LITE_INITIATOR_RESPONSE_REGISTER_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_status;

    rggen_axi4lite_initiator_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) axi_if ();

    rggen_axi4lite_initiator #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_request_valid(req_valid), .o_request_ready(req_ready),
        .i_request_write(req_write), .i_request_address(req_addr),
        .i_request_write_data(req_wdata), .i_request_strobe(req_strb),
        .o_response_valid(resp_valid), .i_response_ready(resp_ready),
        .o_response_read_data(resp_rdata), .o_response_status(resp_status),
        .axi(axi_if)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int cfg_aw_dly, cfg_w_dly, cfg_ar_dly, cfg_b_dly, cfg_r_dly, cfg_host_dly;
    logic [1:0]  cfg_resp;
    logic [31:0] cfg_rdata;
    bit          cfg_use_mem, cfg_hold_req;

    // Observations of the last transaction
    int r_accept, r_aw_hs, r_w_hs, r_ar_hs, r_resp_first, r_resp_hs, r_bready_first, r_rready_first;
    int r_awv, r_wv, r_arv, r_bad_fields, r_ready_busy, r_resp_unstable, r_bready_host_low;
    logic [7:0]  r_awaddr, r_araddr;
    logic [31:0] r_wdata, r_rdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_status;

    logic [31:0] slv_mem [64];
    logic [31:0] ref_mem [64];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    task automatic drive_idle();
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_strb = '0; resp_ready = 0;
        axi_if.awready = 0; axi_if.wready = 0; axi_if.arready = 0;
        axi_if.bvalid = 0; axi_if.bresp = '0; axi_if.rvalid = 0; axi_if.rdata = '0; axi_if.rresp = '0;
    endtask

    task automatic set_cfg(input int aw, input int w, input int ar, input int b, input int r, input int host,
                           input logic [1:0] resp, input logic [31:0] rd, input bit use_mem, input bit hold);
        cfg_aw_dly = aw; cfg_w_dly = w; cfg_ar_dly = ar; cfg_b_dly = b; cfg_r_dly = r; cfg_host_dly = host;
        cfg_resp = resp; cfg_rdata = rd; cfg_use_mem = use_mem; cfg_hold_req = hold;
    endtask

    // Drives one host request through a configurable-latency slave and records what happened.
    task automatic run_txn(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, h_cnt = 0, start = cyc;
        bit accepted = 0, aw_done = 0, w_done = 0, b_issued = 0, b_armed = 0, r_armed = 0, done = 0, seen = 0;
        logic [7:0]  slv_araddr = '0;
        logic [31:0] first_rd = '0;
        logic [1:0]  first_st = '0;
        r_accept = -1; r_aw_hs = -1; r_w_hs = -1; r_ar_hs = -1; r_resp_first = -1; r_resp_hs = -1;
        r_bready_first = -1; r_rready_first = -1;
        r_awv = 0; r_wv = 0; r_arv = 0; r_bad_fields = 0; r_ready_busy = 0; r_resp_unstable = 0; r_bready_host_low = 0;
        r_awaddr = '0; r_araddr = '0; r_wdata = '0; r_wstrb = '0; r_rdata = '0; r_status = '0;
        while (!done) begin
            @(negedge clk);
            req_valid = !accepted || cfg_hold_req;
            req_write = wr; req_addr = a; req_wdata = d; req_strb = s;
            axi_if.awready = axi_if.awvalid && (aw_cnt >= cfg_aw_dly);
            axi_if.wready  = axi_if.wvalid && (w_cnt >= cfg_w_dly);
            axi_if.arready = axi_if.arvalid && (ar_cnt >= cfg_ar_dly);
            axi_if.bvalid  = b_armed && (b_cnt >= cfg_b_dly);
            axi_if.bresp   = axi_if.bvalid ? cfg_resp : 2'($urandom);
            axi_if.rvalid  = r_armed && (r_cnt >= cfg_r_dly);
            axi_if.rdata   = axi_if.rvalid ? (cfg_use_mem ? slv_mem[slv_araddr[7:2]] : cfg_rdata) : $urandom;
            axi_if.rresp   = axi_if.rvalid ? cfg_resp : 2'($urandom);
            resp_ready     = (h_cnt >= cfg_host_dly);
            #1;
            cyc++;
            if (!accepted) begin
                if (req_valid && req_ready) begin accepted = 1; r_accept = cyc; end
            end else if (req_ready) r_ready_busy++;
            if (axi_if.awvalid) begin
                r_awv++;
                if (axi_if.awaddr !== a || axi_if.awprot !== 3'b000) r_bad_fields++;
                if (axi_if.awready) begin aw_done = 1; r_aw_hs = cyc; r_awaddr = axi_if.awaddr; end
                else aw_cnt++;
            end
            if (axi_if.wvalid) begin
                r_wv++;
                if (axi_if.wdata !== d || axi_if.wstrb !== s) r_bad_fields++;
                if (axi_if.wready) begin w_done = 1; r_w_hs = cyc; r_wdata = axi_if.wdata; r_wstrb = axi_if.wstrb; end
                else w_cnt++;
            end
            if (axi_if.arvalid) begin
                r_arv++;
                if (axi_if.araddr !== a || axi_if.arprot !== 3'b000) r_bad_fields++;
                if (axi_if.arready) begin
                    r_ar_hs = cyc; r_araddr = axi_if.araddr; slv_araddr = axi_if.araddr; r_armed = 1; r_cnt = 0;
                end else ar_cnt++;
            end
            if (aw_done && w_done && !b_issued) begin
                b_issued = 1; b_armed = 1; b_cnt = 0;
                slv_mem[r_awaddr[7:2]] = merge(slv_mem[r_awaddr[7:2]], r_wdata, r_wstrb);
            end
            if (axi_if.bready && r_bready_first < 0) r_bready_first = cyc;
            if (axi_if.bready && !resp_ready) r_bready_host_low++;
            if (axi_if.rready && r_rready_first < 0) r_rready_first = cyc;
            if (axi_if.bvalid) begin if (axi_if.bready) b_armed = 0; end else if (b_armed) b_cnt++;
            if (axi_if.rvalid) begin if (axi_if.rready) r_armed = 0; end else if (r_armed) r_cnt++;
            if (resp_valid) begin
                if (!seen) begin seen = 1; r_resp_first = cyc; first_rd = resp_rdata; first_st = resp_status; end
                else if (resp_rdata !== first_rd || resp_status !== first_st) r_resp_unstable++;
                if (resp_ready) begin done = 1; r_resp_hs = cyc; r_rdata = resp_rdata; r_status = resp_status; end
                else h_cnt++;
            end else if (seen) r_resp_unstable++;
            if (!done && cyc - start > 200) begin
                checks++; failures++;
                $display("FAIL timeout: no host response after %0d cycles, required one within 200", cyc - start);
                done = 1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
        checks++; if ({axi_if.awvalid, axi_if.wvalid, axi_if.arvalid} !== 3'b000) begin failures++; $display("FAIL rst_axi_valids: got %b expected 000", {axi_if.awvalid, axi_if.wvalid, axi_if.arvalid}); end
        checks++; if ({axi_if.bready, axi_if.rready, resp_valid} !== 3'b000) begin failures++; $display("FAIL rst_readies: got %b expected 000", {axi_if.bready, axi_if.rready, resp_valid}); end
        checks++; if (resp_rdata !== 32'h0 || resp_status !== 2'b00) begin failures++; $display("FAIL rst_resp_data: got %h/%b expected 0/00", resp_rdata, resp_status); end
        @(negedge clk); rst_n = 1; #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_write_basic();
        set_cfg(0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0);
        run_txn(1, 8'h10, 32'hDEADBEEF, 4'hF);
        checks++; if (r_awaddr !== 8'h10) begin failures++; $display("FAIL wr_awaddr: got %h expected 10", r_awaddr); end
        checks++; if (r_wdata !== 32'hDEADBEEF || r_wstrb !== 4'hF) begin failures++; $display("FAIL wr_wdata: got %h/%h expected deadbeef/f", r_wdata, r_wstrb); end
        checks++; if (r_awv !== 1 || r_wv !== 1) begin failures++; $display("FAIL wr_valid_len: got aw=%0d w=%0d expected 1/1", r_awv, r_wv); end
        checks++; if (r_aw_hs !== r_accept + 1) begin failures++; $display("FAIL wr_aw_timing: got %0d expected %0d", r_aw_hs, r_accept + 1); end
        checks++; if (r_status !== 2'b00 || r_rdata !== 32'h0) begin failures++; $display("FAIL wr_resp: got %b/%h expected 00/0", r_status, r_rdata); end
        checks++; if (r_resp_first - r_accept !== EXP_LAT) begin failures++; $display("FAIL wr_latency: got %0d expected %0d", r_resp_first - r_accept, EXP_LAT); end
        checks++; if (r_bad_fields !== 0) begin failures++; $display("FAIL wr_fields: got %0d bad cycles expected 0", r_bad_fields); end
    endtask

    task automatic test_write_late_w();
        set_cfg(0, 3, 0, 0, 0, 0, 2'b01, 32'h0, 0, 0);
        run_txn(1, 8'h20, 32'h0BADF00D, 4'h5);
        checks++; if (r_awv !== 1 || r_wv !== 4) begin failures++; $display("FAIL late_w_valids: got aw=%0d w=%0d expected 1/4", r_awv, r_wv); end
        checks++; if (r_w_hs !== r_aw_hs + 3) begin failures++; $display("FAIL late_w_gap: got %0d expected %0d", r_w_hs - r_aw_hs, 3); end
        checks++; if (r_bready_first !== r_w_hs + 1) begin failures++; $display("FAIL late_w_wait_entry: got %0d expected %0d", r_bready_first, r_w_hs + 1); end
        checks++; if (r_status !== 2'b01 || r_bad_fields !== 0) begin failures++; $display("FAIL late_w_resp: got %b bad=%0d expected 01 bad=0", r_status, r_bad_fields); end
    endtask

    task automatic test_read();
        set_cfg(0, 0, 2, 0, 0, 0, 2'b10, 32'h12345678, 0, 0);
        run_txn(0, 8'h24, 32'h0, 4'h0);
        checks++; if (r_araddr !== 8'h24 || r_arv !== 3) begin failures++; $display("FAIL rd_ar: got %h len=%0d expected 24 len=3", r_araddr, r_arv); end
        checks++; if (r_rdata !== 32'h12345678 || r_status !== 2'b10) begin failures++; $display("FAIL rd_resp: got %h/%b expected 12345678/10", r_rdata, r_status); end
        checks++; if (r_rready_first !== r_ar_hs + 1) begin failures++; $display("FAIL rd_wait_entry: got %0d expected %0d", r_rready_first, r_ar_hs + 1); end
        checks++; if (r_resp_first - r_ar_hs !== EXP_LAT - 1) begin failures++; $display("FAIL rd_latency: got %0d expected %0d", r_resp_first - r_ar_hs, EXP_LAT - 1); end
    endtask

    task automatic test_back_to_back();
        int prev_hs;
        set_cfg(0, 0, 0, 0, 0, 4, 2'b01, 32'h0, 0, 1);
        run_txn(1, 8'h40, 32'hCAFEF00D, 4'h3);
        prev_hs = r_resp_hs;
        checks++; if (r_ready_busy !== 0) begin failures++; $display("FAIL stall_req_ready: got %0d ready cycles expected 0", r_ready_busy); end
        checks++; if (r_resp_unstable !== 0 || r_resp_hs - r_resp_first !== 4) begin failures++; $display("FAIL stall_hold: got unstable=%0d held=%0d expected 0/4", r_resp_unstable, r_resp_hs - r_resp_first); end
        checks++; if (r_status !== 2'b01 || r_rdata !== 32'h0) begin failures++; $display("FAIL stall_resp: got %b/%h expected 01/0", r_status, r_rdata); end
`ifdef RGGEN_AXI4LITE_INITIATOR_RESPONSE_REGISTER_EN
        checks++; if (r_bready_host_low < 1) begin failures++; $display("FAIL stall_bready: got %0d cycles bready without host ready expected >0", r_bready_host_low); end
`else
        checks++; if (r_bready_host_low !== 0) begin failures++; $display("FAIL stall_bready: got %0d cycles bready without host ready expected 0", r_bready_host_low); end
`endif
        set_cfg(0, 0, 0, 0, 0, 0, 2'b00, 32'hA5A55A5A, 0, 0);
        run_txn(0, 8'h44, 32'h0, 4'h0);
        checks++; if (r_accept !== prev_hs + 1) begin failures++; $display("FAIL b2b_accept: got %0d expected %0d", r_accept, prev_hs + 1); end
        checks++; if (r_rdata !== 32'hA5A55A5A || r_status !== 2'b00) begin failures++; $display("FAIL b2b_resp: got %h/%b expected a5a55a5a/00", r_rdata, r_status); end
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        @(negedge clk); drive_idle();
        req_valid = 1; req_write = 1; req_addr = 8'h30; req_wdata = 32'h11223344; req_strb = 4'hF;
        @(negedge clk); drive_idle(); #1;
        checks++; if (axi_if.awvalid !== 1'b1) begin failures++; $display("FAIL mid_awvalid_pre: got %b expected 1", axi_if.awvalid); end
        @(negedge clk); rst_n = 0; axi_if.bvalid = 1; resp_ready = 1;
        @(negedge clk); #1;
        checks++; if ({axi_if.awvalid, axi_if.wvalid, axi_if.arvalid, resp_valid} !== 4'b0000) begin failures++; $display("FAIL mid_reset_valids: got %b expected 0000", {axi_if.awvalid, axi_if.wvalid, axi_if.arvalid, resp_valid}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rst_n = 1; #1;
            if (resp_valid || axi_if.bready) spurious++;
        end
        checks++; if (spurious !== 0) begin failures++; $display("FAIL mid_no_response: got %0d response cycles expected 0", spurious); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_idle: got req_ready %b expected 1", req_ready); end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_random();
        bit wr;
        logic [7:0] a;
        logic [31:0] d, exp_rd;
        logic [3:0] s;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom); a = 8'($urandom_range(0, 63) * 4); d = $urandom; s = 4'($urandom);
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), 32'h0, 1, 1'($urandom));
            exp_rd = wr ? 32'h0 : ref_mem[a[7:2]];
            if (wr) ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, s);
            run_txn(wr, a, d, s);
            checks++; if (r_rdata !== exp_rd || r_status !== cfg_resp) begin failures++; $display("FAIL rand_resp[%0d]: got %h/%b expected %h/%b", i, r_rdata, r_status, exp_rd, cfg_resp); end
            checks++; if (r_bad_fields !== 0 || r_ready_busy !== 0 || r_resp_unstable !== 0) begin failures++; $display("FAIL rand_proto[%0d]: got bad=%0d busy=%0d unstable=%0d expected 0/0/0", i, r_bad_fields, r_ready_busy, r_resp_unstable); end
        end
        @(negedge clk); drive_idle();
    endtask

    initial begin
        drive_idle();
        set_cfg(0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0);
        for (int i = 0; i < 64; i++) begin ref_mem[i] = $urandom; slv_mem[i] = ref_mem[i]; end
        test_reset();
        test_write_basic();
        test_write_late_w();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
